// File: rtl/puf_challenge_sequencer_if.sv
// Host-side handshake for the PUF challenge sequencer: word request and response delivery.
interface puf_challenge_sequencer_if #(
    parameter int unsigned N_STAGES = 8,
    parameter int unsigned N_BITS   = 8
);
    logic                start;
    logic [N_STAGES-1:0] seed;
    logic                busy;
    logic [N_BITS-1:0]   resp_word;
    logic                resp_valid;
    logic                resp_ready;

    // Host side: requests words and consumes responses.
    modport master (
        output start, seed, resp_ready,
        input  busy, resp_word, resp_valid
    );

    // Sequencer side.
    modport slave (
        input  start, seed, resp_ready,
        output busy, resp_word, resp_valid
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: launches repeated races per challenge, majority-votes the
// synchronized arbiter output into one response bit, and steps the challenge by an LFSR.
// REPEAT must be odd and SETTLE_CYC at least 3 (it covers the 2-flop synchronizer delay).
// Tap table covers N_STAGES 2..16 and 32.
module puf_challenge_sequencer #(
    parameter int unsigned N_STAGES   = 8,
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned REPEAT     = 3,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    puf_challenge_sequencer_if.slave host,
    output logic [N_STAGES-1:0] chal,
    output logic                race_a,
    output logic                race_b,
    input  logic                arb_resp
);

    localparam int unsigned CntW = $clog2(REPEAT + 1);
    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned IdxW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    // Maximal-length feedback taps, bit k set means chal[k] feeds the new bit 0.
    function automatic logic [31:0] tap_mask(input int unsigned n);
        logic [31:0] m;
        case (n)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            32:      m = 32'h8020_0003;
            // Unlisted widths fall back to the top two bits; the zero guard still holds.
            default: m = (n >= 2) ? (32'h3 << (n - 2)) : 32'h1;
        endcase
        return m;
    endfunction

    localparam logic [31:0]         TapMask32 = tap_mask(N_STAGES);
    localparam logic [N_STAGES-1:0] TapMask   = TapMask32[N_STAGES-1:0];
    localparam logic [N_STAGES-1:0] ChalOne   = {{(N_STAGES - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StFire,
        StSample,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [N_STAGES-1:0] chal_q, chal_d;
    logic [N_BITS-1:0]   word_q, word_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [CntW-1:0]     ones_q, ones_d;
    logic [CntW-1:0]     eval_q, eval_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic                arb_sync1_q, arb_sync2_q;

    logic [CntW-1:0]     ones_sum;
    logic [CntW-1:0]     eval_sum;
    logic [N_STAGES-1:0] chal_step;

    // Two-flop synchronizer for the asynchronous arbiter latch output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_sync1_q <= 1'b0;
            arb_sync2_q <= 1'b0;
        end else begin
            arb_sync1_q <= arb_resp;
            arb_sync2_q <= arb_sync1_q;
        end
    end

    // Next LFSR challenge; a zero result is replaced by 1 so the chain never locks up.
    always_comb begin
        chal_step = {chal_q[N_STAGES-2:0], ^(chal_q & TapMask)};
        if (chal_step == '0) begin
            chal_step = ChalOne;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            chal_q    <= '0;
            word_q    <= '0;
            bit_idx_q <= '0;
            ones_q    <= '0;
            eval_q    <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            chal_q    <= chal_d;
            word_q    <= word_d;
            bit_idx_q <= bit_idx_d;
            ones_q    <= ones_d;
            eval_q    <= eval_d;
            settle_q  <= settle_d;
        end
    end

    // Sequencing: ARM (race low) -> FIRE (race high, settle) -> SAMPLE (vote) per evaluation.
    always_comb begin
        state_d   = state_q;
        chal_d    = chal_q;
        word_d    = word_q;
        bit_idx_d = bit_idx_q;
        ones_d    = ones_q;
        eval_d    = eval_q;
        settle_d  = settle_q;
        ones_sum  = ones_q + CntW'(arb_sync2_q);
        eval_sum  = eval_q + CntW'(1);

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    chal_d    = (host.seed == '0) ? ChalOne : host.seed;
                    word_d    = '0;
                    bit_idx_d = '0;
                    ones_d    = '0;
                    eval_d    = '0;
                    state_d   = StArm;
                end
            end
            StArm: begin
                settle_d = '0;
                state_d  = StFire;
            end
            StFire: begin
                settle_d = settle_q + SetW'(1);
                if (settle_q == SetW'(SETTLE_CYC - 1)) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (eval_sum == CntW'(REPEAT)) begin
                    word_d[bit_idx_q] = (ones_sum > CntW'(REPEAT / 2));
                    ones_d    = '0;
                    eval_d    = '0;
                    chal_d    = chal_step;
                    bit_idx_d = bit_idx_q + IdxW'(1);
                    state_d   = (bit_idx_q == IdxW'(N_BITS - 1)) ? StDone : StArm;
                end else begin
                    ones_d  = ones_sum;
                    eval_d  = eval_sum;
                    state_d = StArm;
                end
            end
            StDone: begin
                if (host.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        chal            = chal_q;
        race_a          = (state_q == StFire) || (state_q == StSample);
        race_b          = race_a;
        host.busy       = (state_q != StIdle);
        host.resp_valid = (state_q == StDone);
        host.resp_word  = word_q;
    end

endmodule
